// File: rtl/alu_scalar_seq_module.sv
// alu_scalar_seq_module: multiplies a flattened signed matrix by a signed scalar,
// LANES elements per clock. One `start` strobe launches an operation; `done`
// pulses for one cycle once every group has been written into C_flat.
// Optional feature macro: ALU_SCALAR_SAT_EN (saturate overflowing elements
// instead of wrapping them).
//
// state | meaning
// IDLE  | waiting for start; outputs hold the previous result
// RUN   | one group of LANES elements written per clock
// DONE  | one-cycle done pulse, then back to IDLE
module alu_scalar_seq_module #(
    parameter int DATA_W = 8,
    parameter int N_ELEM = 25,
    parameter int LANES  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_ELEM*DATA_W-1:0] A_flat,
    input  logic [DATA_W-1:0]        scalar,
    output logic                     busy,
    output logic                     done,
    output logic [N_ELEM*DATA_W-1:0] C_flat,
    output logic                     overflow_flag
);

    localparam int N_GRP = (N_ELEM + LANES - 1) / LANES;
    localparam int GRP_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(N_GRP - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                     state;
    logic [GRP_W-1:0]           grp_idx;
    logic [N_ELEM*DATA_W-1:0]   a_lat;
    logic [DATA_W-1:0]          s_lat;

    int                         lane_idx [LANES];
    logic                       lane_vld [LANES];
    logic signed [DATA_W-1:0]   lane_a   [LANES];
    logic signed [2*DATA_W-1:0] lane_p   [LANES];
    logic                       lane_ovf [LANES];
    logic [DATA_W-1:0]          lane_res [LANES];
    logic                       grp_ovf;

    // Per-lane multiply of the current group; lanes past N_ELEM are masked off.
    always_comb begin
        grp_ovf = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = int'(grp_idx) * LANES + l;
            lane_vld[l] = (lane_idx[l] < N_ELEM);
            lane_a[l]   = '0;
            if (lane_vld[l]) begin
                lane_a[l] = a_lat[lane_idx[l]*DATA_W +: DATA_W];
            end
            lane_p[l]   = lane_a[l] * $signed(s_lat);
            // Overflow when the upper half is not a sign extension of the result MSB.
            lane_ovf[l] = lane_vld[l] &&
                          !((&lane_p[l][2*DATA_W-1:DATA_W-1]) ||
                            (~|lane_p[l][2*DATA_W-1:DATA_W-1]));
`ifdef ALU_SCALAR_SAT_EN
            if (lane_ovf[l]) begin
                lane_res[l] = lane_p[l][2*DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                    : {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                lane_res[l] = lane_p[l][DATA_W-1:0];
            end
`else
            lane_res[l] = lane_p[l][DATA_W-1:0];
`endif
            grp_ovf = grp_ovf | lane_ovf[l];
        end
    end

    // Control FSM with registered busy/done and group-wise result writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            grp_idx       <= '0;
            a_lat         <= '0;
            s_lat         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            C_flat        <= '0;
            overflow_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_lat         <= A_flat;
                        s_lat         <= scalar;
                        grp_idx       <= '0;
                        overflow_flag <= 1'b0;
                        busy          <= 1'b1;
                        state         <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_vld[l]) begin
                            C_flat[lane_idx[l]*DATA_W +: DATA_W] <= lane_res[l];
                        end
                    end
                    overflow_flag <= overflow_flag | grp_ovf;
                    if (grp_idx == LAST_GRP) begin
                        grp_idx <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        grp_idx <= grp_idx + GRP_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
